// File: rtl/ascii_input_control.sv
// ascii_input_control
// Collects ASCII characters from board switches, one per debounced KEY press,
// packs up to four of them into a word (first character in the MSB byte,
// unused bytes are spaces) and hands the word to the CPU with a valid flag.
//
// state   | meaning
// --------+---------------------------------------------------------------
// COLLECT | accepting characters; enter appends, send/fill completes word
// READY   | word frozen and valid; only a CPU read releases it
module ascii_input_control #(
    parameter int ASCII_LEN       = 8,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [ASCII_LEN-1:0]   SW,
    input  logic                   KEY_enter,
    input  logic                   KEY_send,
    input  logic                   KEY_clear,
    input  logic                   rd_en,
    output logic [4*ASCII_LEN-1:0] bytes_4,
    output logic                   valid,
    output logic [2:0]             count,
    output logic                   overflow
);

    localparam int                     CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]       CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [ASCII_LEN-1:0]   SPACE    = ASCII_LEN'(32);
    localparam logic [4*ASCII_LEN-1:0] BLANK    = {4{SPACE}};

    typedef enum logic {COLLECT, READY} state_t;

    // key index: 0 = enter, 1 = send, 2 = clear
    logic [2:0]           key_raw;
    logic [2:0]           key_meta;
    logic [2:0]           key_sync;
    logic [2:0]           key_db;
    logic [2:0]           key_armed;
    logic [2:0]           key_press;
    logic [CNT_W-1:0]     db_cnt [3];
    logic [ASCII_LEN-1:0] sw_meta;
    logic [ASCII_LEN-1:0] sw_sync;

    state_t                 state, state_nxt;
    logic [4*ASCII_LEN-1:0] bytes_nxt;
    logic                   valid_nxt;
    logic [2:0]             count_nxt;
    logic                   overflow_nxt;

    assign key_raw = {KEY_clear, KEY_send, KEY_enter};

    // Two-flop synchronisers for the keys and the switch bus. Keys come out
    // of reset reading "pressed" so a button held through reset is never
    // armed until it has actually been seen released.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_meta <= '0;
            key_sync <= '0;
            sw_meta  <= '0;
            sw_sync  <= '0;
        end else begin
            key_meta <= key_raw;
            key_sync <= key_meta;
            sw_meta  <= SW;
            sw_sync  <= sw_meta;
        end
    end

    // Per-key debounce: level flips after DEBOUNCE_CYCLES consecutive
    // differing samples; a press pulse fires only on an armed 1->0 flip.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                db_cnt[i] <= '0;
            end
            key_db    <= '1;
            key_armed <= '0;
            key_press <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                key_press[i] <= 1'b0;
                if (key_sync[i] != key_db[i]) begin
                    if (db_cnt[i] == CNT_LAST) begin
                        key_db[i]    <= key_sync[i];
                        db_cnt[i]    <= '0;
                        key_press[i] <= key_db[i] & ~key_sync[i] & key_armed[i];
                    end else begin
                        db_cnt[i] <= db_cnt[i] + CNT_W'(1);
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
                key_armed[i] <= key_armed[i] | key_sync[i];
            end
        end
    end

    // Word-assembly state register and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= COLLECT;
            bytes_4  <= BLANK;
            valid    <= 1'b0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            state    <= state_nxt;
            bytes_4  <= bytes_nxt;
            valid    <= valid_nxt;
            count    <= count_nxt;
            overflow <= overflow_nxt;
        end
    end

    // Next-state and output logic; priority rd_en > clear > enter > send.
    always_comb begin
        state_nxt    = state;
        bytes_nxt    = bytes_4;
        valid_nxt    = valid;
        count_nxt    = count;
        overflow_nxt = overflow;
        case (state)
            COLLECT: begin
                if (key_press[2]) begin
                    bytes_nxt    = BLANK;
                    count_nxt    = '0;
                    overflow_nxt = 1'b0;
                end else if (key_press[0]) begin
                    if (count < 3'd4) begin
                        bytes_nxt[(3 - int'(count)) * ASCII_LEN +: ASCII_LEN] = sw_sync;
                        count_nxt = count + 3'd1;
                        if (count == 3'd3) begin
                            state_nxt = READY;
                            valid_nxt = 1'b1;
                        end
                    end
                end else if (key_press[1] && count != 3'd0) begin
                    state_nxt = READY;
                    valid_nxt = 1'b1;
                end
            end
            READY: begin
                if (rd_en) begin
                    state_nxt = COLLECT;
                    valid_nxt = 1'b0;
                    bytes_nxt = BLANK;
                    count_nxt = '0;
                end else if (key_press[0] && !key_press[2]) begin
                    // clear is ignored here but still outranks a same-cycle enter
                    overflow_nxt = 1'b1;
                end
            end
            default: begin
                state_nxt = COLLECT;
            end
        endcase
    end

endmodule

// File: tb/tb_ascii_input_control.sv
// Bench for ascii_input_control: a queue-based model of the character buffer
// fed by a sample-count debounce model, compared every cycle, plus literal
// expectations at the points of interest.
module tb_ascii_input_control;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  SW = 8'h00;
    logic        KEY_enter = 1'b1;
    logic        KEY_send = 1'b1;
    logic        KEY_clear = 1'b1;
    logic        rd_en = 1'b0;
    logic [31:0] bytes_4;
    logic        valid;
    logic [2:0]  count;
    logic        overflow;

    int checks = 0;
    int errors = 0;

    ascii_input_control #(.ASCII_LEN(8), .DEBOUNCE_CYCLES(N)) dut (
        .clk(clk), .rst_n(rst_n), .SW(SW),
        .KEY_enter(KEY_enter), .KEY_send(KEY_send), .KEY_clear(KEY_clear),
        .rd_en(rd_en), .bytes_4(bytes_4), .valid(valid),
        .count(count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [7:0] m_chars[$];
    bit         m_ready;
    bit         m_ovf;
    bit  [2:0]  m_db;
    bit  [2:0]  m_armed;
    int         m_run [3];
    bit  [2:0]  ev_q [3];
    logic [7:0] sw_h1, sw_h2;

    function automatic logic [31:0] m_bytes();
        logic [31:0] r;
        for (int i = 0; i < 4; i++)
            r[31 - 8*i -: 8] = (i < m_chars.size()) ? m_chars[i] : 8'h20;
        return r;
    endfunction

    task automatic model_reset();
        m_chars.delete();
        m_ready = 0;
        m_ovf   = 0;
        m_db    = 3'b111;
        m_armed = 3'b000;
        for (int k = 0; k < 3; k++) begin
            m_run[k] = 0;
            ev_q[k]  = 3'b000;
        end
        sw_h1 = 8'h00;
        sw_h2 = 8'h00;
    endtask

    // A key level is accepted after N consecutive differing samples; the
    // resulting press takes effect on the outputs three sampling edges later.
    initial begin : model
        bit [2:0]   raw, ev_now, ap;
        logic [7:0] ap_sw;
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                model_reset();
            end else begin
                raw = {KEY_clear, KEY_send, KEY_enter};
                ev_now = 3'b000;
                for (int k = 0; k < 3; k++) begin
                    if (raw[k] != m_db[k]) m_run[k]++;
                    else m_run[k] = 0;
                    if (m_run[k] == N) begin
                        m_db[k]  = raw[k];
                        m_run[k] = 0;
                        if (!raw[k] && m_armed[k]) ev_now[k] = 1'b1;
                    end
                    if (raw[k]) m_armed[k] = 1'b1;
                end
                ap    = ev_q[2];
                ap_sw = sw_h2;
                ev_q[2] = ev_q[1];
                ev_q[1] = ev_q[0];
                ev_q[0] = ev_now;
                sw_h2 = sw_h1;
                sw_h1 = SW;
                if (m_ready) begin
                    if (rd_en) begin
                        m_chars.delete();
                        m_ready = 0;
                    end else if (!ap[2] && ap[0]) begin
                        m_ovf = 1;
                    end
                end else begin
                    if (ap[2]) begin
                        m_chars.delete();
                        m_ovf = 0;
                    end else if (ap[0]) begin
                        m_chars.push_back(ap_sw);
                        if (m_chars.size() == 4) m_ready = 1;
                    end else if (ap[1] && m_chars.size() > 0) begin
                        m_ready = 1;
                    end
                end
            end
        end
    end

    // Every-cycle comparison against the model.
    initial begin : compare
        forever begin
            @(negedge clk);
            if (rst_n) begin
                check("model bytes_4", bytes_4, m_bytes());
                check("model valid", {31'd0, valid}, {31'd0, m_ready});
                check("model count", {29'd0, count}, 32'(m_chars.size()));
                check("model overflow", {31'd0, overflow}, {31'd0, m_ovf});
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_key(input int k, input logic v);
        case (k)
            0: KEY_enter = v;
            1: KEY_send  = v;
            default: KEY_clear = v;
        endcase
    endtask

    task automatic press(input int k, input logic [7:0] c);
        SW = c;
        cyc(2);
        set_key(k, 1'b0);
        cyc(8);
        set_key(k, 1'b1);
        cyc(8);
    endtask

    task automatic read_word();
        rd_en = 1'b1;
        cyc(1);
        rd_en = 1'b0;
        cyc(2);
    endtask

    task automatic lit(input string name, input logic [31:0] b, input logic v,
                       input logic [2:0] c, input logic o);
        check({name, " bytes_4"}, bytes_4, b);
        check({name, " valid"}, {31'd0, valid}, {31'd0, v});
        check({name, " count"}, {29'd0, count}, {29'd0, c});
        check({name, " overflow"}, {31'd0, overflow}, {31'd0, o});
    endtask

    initial begin : stim
        cyc(3);
        lit("in reset", 32'h20202020, 0, 3'd0, 0);
        rst_n = 1'b1;
        cyc(3);
        lit("after reset", 32'h20202020, 0, 3'd0, 0);

        // three characters then send
        press(0, 8'h48);
        press(0, 8'h69);
        press(0, 8'h21);
        lit("three chars", 32'h48692120, 0, 3'd3, 0);
        press(1, 8'h21);
        lit("send", 32'h48692120, 1, 3'd3, 0);
        read_word();
        lit("read", 32'h20202020, 0, 3'd0, 0);

        // four characters fill the word, fifth overflows
        press(0, 8'h31);
        press(0, 8'h32);
        press(0, 8'h33);
        press(0, 8'h34);
        lit("full word", 32'h31323334, 1, 3'd4, 0);
        press(0, 8'h35);
        lit("overflow", 32'h31323334, 1, 3'd4, 1);
        read_word();
        lit("read keeps ovf", 32'h20202020, 0, 3'd0, 1);
        press(2, 8'h00);
        lit("clear ovf", 32'h20202020, 0, 3'd0, 0);

        // bouncing enter then held low: one character
        SW = 8'h41;
        cyc(2);
        KEY_enter = 1'b0; cyc(2);
        KEY_enter = 1'b1; cyc(2);
        KEY_enter = 1'b0; cyc(12);
        KEY_enter = 1'b1; cyc(10);
        lit("bounce", 32'h41202020, 0, 3'd1, 0);
        // short glitch: nothing
        SW = 8'h42;
        cyc(2);
        KEY_enter = 1'b0; cyc(3);
        KEY_enter = 1'b1; cyc(10);
        lit("glitch", 32'h41202020, 0, 3'd1, 0);

        // rd_en while collecting does nothing
        read_word();
        lit("rd in collect", 32'h41202020, 0, 3'd1, 0);

        // clear in COLLECT
        press(2, 8'h00);
        press(0, 8'h57);
        lit("enter 57", 32'h57202020, 0, 3'd1, 0);
        press(2, 8'h00);
        lit("clear", 32'h20202020, 0, 3'd0, 0);

        // clear in READY ignored
        press(0, 8'h58);
        press(1, 8'h58);
        press(2, 8'h58);
        lit("clear in ready", 32'h58202020, 1, 3'd1, 0);
        read_word();

        // reset mid-word with enter held through reset
        press(0, 8'h61);
        press(0, 8'h62);
        lit("two chars", 32'h61622020, 0, 3'd2, 0);
        SW = 8'h66;
        KEY_enter = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        lit("async reset", 32'h20202020, 0, 3'd0, 0);
        cyc(3);
        rst_n = 1'b1;
        cyc(15);
        lit("held through reset", 32'h20202020, 0, 3'd0, 0);
        KEY_enter = 1'b1;
        cyc(10);
        lit("released after reset", 32'h20202020, 0, 3'd0, 0);
        press(0, 8'h63);
        lit("rearmed", 32'h63202020, 0, 3'd1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
